// File: rtl/adder_cla_pipe.sv
// adder_cla_pipe: pipelined carry-lookahead adder/subtractor with
// valid/ready handshake and backpressure.
//
// Parameters:
//   BW_DATA  operand/result width (multiple of BW_GRP)
//   BW_GRP   bits per lookahead group
//   N_STG    pipeline stages; (BW_DATA/BW_GRP) must be a multiple of N_STG
//
// Ports:
//   i_clk, i_rst        clock, synchronous active-high reset
//   i_valid / o_ready   input handshake
//   i_A, i_B, i_Cin     operands and carry-in (carry-in ignored when subtracting)
//   i_sub               0: A+B+Cin, 1: A-B
//   o_valid / i_ready   output handshake
//   o_S, o_Cout, o_Ovf  result, carry-out (1 = no borrow), signed overflow
//
// Optional feature macro: ADDER_CLA_PIPE_OVF_EN
//   defined   : o_Ovf computed from sign bits carried down the pipeline
//   undefined : o_Ovf tied to 0 and the sign-bit registers are absent
module adder_cla_pipe #(
  parameter int BW_DATA = 32,
  parameter int BW_GRP  = 4,
  parameter int N_STG   = 2
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_valid,
  output logic               o_ready,
  input  logic [BW_DATA-1:0] i_A,
  input  logic [BW_DATA-1:0] i_B,
  input  logic               i_Cin,
  input  logic               i_sub,
  output logic               o_valid,
  input  logic               i_ready,
  output logic [BW_DATA-1:0] o_S,
  output logic               o_Cout,
  output logic               o_Ovf
);

  localparam int N_GRP = BW_DATA / BW_GRP;
  localparam int GPS   = N_GRP / N_STG;
  localparam int SEG   = GPS * BW_GRP;

  logic               w_stall;
  logic               w_adv;
  logic [BW_DATA-1:0] w_b_eff;
  logic               w_c0;

  // Whole pipe freezes when the output is held by downstream.
  assign w_stall = o_valid & ~i_ready;
  assign w_adv   = ~w_stall;
  assign o_ready = ~w_stall;

  // Subtract is A + ~B + 1, so the carry-in is forced high.
  assign w_b_eff = i_sub ? ~i_B : i_B;
  assign w_c0    = i_sub | i_Cin;

  // One segment of lookahead groups. Returns {carry_out, sum}.
  // Group carry-outs come from the group G/P terms, so the chain
  // between groups is one AND-OR per group.
  function automatic logic [SEG:0] f_cla(
    input logic [SEG-1:0] a,
    input logic [SEG-1:0] b,
    input logic           ci
  );
    logic [SEG-1:0] p;
    logic [SEG-1:0] g;
    logic [SEG-1:0] s;
    logic           c;
    logic           cb;
    logic           gg;
    logic           pg;
    p = a ^ b;
    g = a & b;
    s = '0;
    c = ci;
    for (int j = 0; j < GPS; j++) begin
      gg = 1'b0;
      pg = 1'b1;
      for (int i = 0; i < BW_GRP; i++) begin
        gg = g[j*BW_GRP+i] | (p[j*BW_GRP+i] & gg);
        pg = pg & p[j*BW_GRP+i];
      end
      cb = c;
      for (int i = 0; i < BW_GRP; i++) begin
        s[j*BW_GRP+i] = p[j*BW_GRP+i] ^ cb;
        cb = g[j*BW_GRP+i] | (p[j*BW_GRP+i] & cb);
      end
      c = gg | (pg & c);
    end
    return {c, s};
  endfunction

  for (genvar k = 0; k < N_STG; k++) begin : g_stg
    // Width of operand slices still to be consumed after this stage.
    localparam int HW = BW_DATA - (k + 1) * SEG;

    logic [SEG-1:0]       w_a;
    logic [SEG-1:0]       w_b;
    logic                 w_ci;
    logic                 w_vi;
    logic [SEG:0]         w_r;
    logic [(k+1)*SEG-1:0] w_s;
    logic                 r_vld;
    logic                 r_c;
    logic [(k+1)*SEG-1:0] r_s;
`ifdef ADDER_CLA_PIPE_OVF_EN
    logic                 w_sa;
    logic                 w_sb;
`endif

    if (k == 0) begin : g_src
      assign w_a  = i_A[SEG-1:0];
      assign w_b  = w_b_eff[SEG-1:0];
      assign w_ci = w_c0;
      assign w_vi = i_valid;
      assign w_s  = w_r[SEG-1:0];
`ifdef ADDER_CLA_PIPE_OVF_EN
      assign w_sa = i_A[BW_DATA-1];
      assign w_sb = w_b_eff[BW_DATA-1];
`endif
    end else begin : g_src
      assign w_a  = g_stg[k-1].g_hi.r_a[SEG-1:0];
      assign w_b  = g_stg[k-1].g_hi.r_b[SEG-1:0];
      assign w_ci = g_stg[k-1].r_c;
      assign w_vi = g_stg[k-1].r_vld;
      assign w_s  = {w_r[SEG-1:0], g_stg[k-1].r_s};
`ifdef ADDER_CLA_PIPE_OVF_EN
      assign w_sa = g_stg[k-1].g_hi.r_sa;
      assign w_sb = g_stg[k-1].g_hi.r_sb;
`endif
    end

    assign w_r = f_cla(w_a, w_b, w_ci);

    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        r_vld <= 1'b0;
        r_c   <= 1'b0;
        r_s   <= '0;
      end else if (w_adv) begin
        r_vld <= w_vi;
        r_c   <= w_r[SEG];
        r_s   <= w_s;
      end
    end

    if (k < N_STG - 1) begin : g_hi
      logic [HW-1:0] w_an;
      logic [HW-1:0] w_bn;
      logic [HW-1:0] r_a;
      logic [HW-1:0] r_b;
`ifdef ADDER_CLA_PIPE_OVF_EN
      logic          r_sa;
      logic          r_sb;
`endif

      if (k == 0) begin : g_ld
        assign w_an = i_A[BW_DATA-1:SEG];
        assign w_bn = w_b_eff[BW_DATA-1:SEG];
      end else begin : g_ld
        assign w_an = g_stg[k-1].g_hi.r_a[HW+SEG-1:SEG];
        assign w_bn = g_stg[k-1].g_hi.r_b[HW+SEG-1:SEG];
      end

      always_ff @(posedge i_clk) begin
        if (i_rst) begin
          r_a <= '0;
          r_b <= '0;
        end else if (w_adv) begin
          r_a <= w_an;
          r_b <= w_bn;
        end
      end

`ifdef ADDER_CLA_PIPE_OVF_EN
      always_ff @(posedge i_clk) begin
        if (i_rst) begin
          r_sa <= 1'b0;
          r_sb <= 1'b0;
        end else if (w_adv) begin
          r_sa <= w_sa;
          r_sb <= w_sb;
        end
      end
`endif
    end else begin : g_out
`ifdef ADDER_CLA_PIPE_OVF_EN
      logic r_ovf;

      // Like-signed operands giving an opposite-signed result.
      always_ff @(posedge i_clk) begin
        if (i_rst) begin
          r_ovf <= 1'b0;
        end else if (w_adv) begin
          r_ovf <= (w_sa == w_sb) & (w_r[SEG-1] != w_sa);
        end
      end
`endif
    end
  end

  assign o_valid = g_stg[N_STG-1].r_vld;
  assign o_S     = g_stg[N_STG-1].r_s;
  assign o_Cout  = g_stg[N_STG-1].r_c;
`ifdef ADDER_CLA_PIPE_OVF_EN
  assign o_Ovf   = g_stg[N_STG-1].g_out.r_ovf;
`else
  assign o_Ovf   = 1'b0;
`endif

endmodule

// File: tb/tb_adder_cla_pipe.sv
// Directed bench for adder_cla_pipe (32-bit, 4-bit groups, 2 stages):
// vector table, backpressure, mid-stream reset and random-ready stream.
module tb_adder_cla_pipe;
  localparam int W  = 32;
  localparam int NS = 2;
`ifdef ADDER_CLA_PIPE_OVF_EN
  localparam bit OVF = 1'b1;
`else
  localparam bit OVF = 1'b0;
`endif

  logic         i_clk = 1'b0;
  logic         i_rst;
  logic         i_valid;
  logic         o_ready;
  logic [W-1:0] i_A;
  logic [W-1:0] i_B;
  logic         i_Cin;
  logic         i_sub;
  logic         o_valid;
  logic         i_ready;
  logic [W-1:0] o_S;
  logic         o_Cout;
  logic         o_Ovf;

  int n_chk = 0;
  int n_err = 0;

  adder_cla_pipe #(
    .BW_DATA(W),
    .BW_GRP (4),
    .N_STG  (NS)
  ) dut (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_valid(i_valid),
    .o_ready(o_ready),
    .i_A    (i_A),
    .i_B    (i_B),
    .i_Cin  (i_Cin),
    .i_sub  (i_sub),
    .o_valid(o_valid),
    .i_ready(i_ready),
    .o_S    (o_S),
    .o_Cout (o_Cout),
    .o_Ovf  (o_Ovf)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        sub;
    logic [31:0] s;
    logic        co;
    logic        ov;
  } vec_t;

  vec_t tv[12];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Behavioural reference: {ovf, cout, sum}.
  function automatic logic [33:0] mdl(input logic [31:0] a,
                                      input logic [31:0] b,
                                      input logic cin,
                                      input logic sub);
    logic [32:0] full;
    logic signed [33:0] sfull;
    logic ov;
    if (sub) begin
      full  = {1'b0, a} + {1'b0, ~b} + 33'd1;
      sfull = $signed({a[31], a[31], a}) - $signed({b[31], b[31], b});
    end else begin
      full  = {1'b0, a} + {1'b0, b} + {32'd0, cin};
      sfull = $signed({a[31], a[31], a}) + $signed({b[31], b[31], b})
              + $signed({33'd0, cin});
    end
    ov = (sfull > 34'sh7FFFFFFF) || (sfull < -34'sh80000000);
    return {ov & OVF, full};
  endfunction

  task automatic drive(input logic v, input logic [31:0] a,
                       input logic [31:0] b, input logic c,
                       input logic s);
    i_valid = v;
    i_A     = a;
    i_B     = b;
    i_Cin   = c;
    i_sub   = s;
  endtask

  task automatic send_chk(input vec_t v, input int idx);
    int lat;
    i_ready = 1'b1;
    drive(1'b1, v.a, v.b, v.cin, v.sub);
    #1;
    chk($sformatf("v%0d_ready", idx), o_ready, 1);
    @(posedge i_clk);
    #1;
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    lat = 1;
    while (!o_valid && lat < 20) begin
      @(posedge i_clk);
      #1;
      lat++;
    end
    chk($sformatf("v%0d_lat", idx), lat, NS);
    chk($sformatf("v%0d_S", idx), o_S, v.s);
    chk($sformatf("v%0d_Cout", idx), o_Cout, v.co);
    chk($sformatf("v%0d_Ovf", idx), o_Ovf, v.ov & OVF);
    @(posedge i_clk);
    #1;
  endtask

  initial begin
    int nxt;
    int got;
    int hold;
    int stale;
    int lat;
    int sent;
    int rcv;
    bit seen;
    logic [33:0] q[$];
    logic [33:0] e;
    logic [31:0] ra;
    logic [31:0] rb;
    logic        rc;
    logic        rs;
    logic [31:0] bp_exp[4];

    tv[0]  = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0,
               32'h00000000, 1'b1, 1'b0};
    tv[1]  = '{32'h00000005, 32'h00000007, 1'b1, 1'b1,
               32'hFFFFFFFE, 1'b0, 1'b0};
    tv[2]  = '{32'h00000007, 32'h00000005, 1'b0, 1'b1,
               32'h00000002, 1'b1, 1'b0};
    tv[3]  = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0,
               32'h80000000, 1'b0, 1'b1};
    tv[4]  = '{32'h80000000, 32'h00000001, 1'b0, 1'b1,
               32'h7FFFFFFF, 1'b1, 1'b1};
    tv[5]  = '{32'h12345678, 32'h0FEDCBA9, 1'b1, 1'b0,
               32'h22222222, 1'b0, 1'b0};
    tv[6]  = '{32'h00000000, 32'h00000000, 1'b1, 1'b0,
               32'h00000001, 1'b0, 1'b0};
    tv[7]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0,
               32'hFFFFFFFF, 1'b1, 1'b0};
    tv[8]  = '{32'h00000000, 32'h00000000, 1'b0, 1'b1,
               32'h00000000, 1'b1, 1'b0};
    tv[9]  = '{32'h0000FFFF, 32'h00000001, 1'b0, 1'b0,
               32'h00010000, 1'b0, 1'b0};
    tv[10] = '{32'h80000000, 32'h80000000, 1'b0, 1'b0,
               32'h00000000, 1'b1, 1'b1};
    tv[11] = '{32'h00000003, 32'h80000000, 1'b0, 1'b1,
               32'h80000003, 1'b0, 1'b1};

    // Reset state
    i_rst   = 1'b1;
    i_ready = 1'b1;
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    repeat (2) @(posedge i_clk);
    #1;
    chk("rst_valid", o_valid, 0);
    chk("rst_S", o_S, 0);
    chk("rst_Cout", o_Cout, 0);
    chk("rst_Ovf", o_Ovf, 0);
    i_rst = 1'b0;
    @(posedge i_clk);
    #1;
    chk("rst_ready", o_ready, 1);

    // Vector table, one operation at a time
    for (int i = 0; i < 12; i++) send_chk(tv[i], i);

    // Backpressure: 4 back-to-back adds, 3-cycle stall on first result
    bp_exp[0] = 32'd2;
    bp_exp[1] = 32'd4;
    bp_exp[2] = 32'd6;
    bp_exp[3] = 32'd8;
    nxt  = 0;
    got  = 0;
    hold = 0;
    seen = 1'b0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      if (o_valid && !seen) seen = 1'b1;
      if (seen && hold < 3) begin
        i_ready = 1'b0;
        hold++;
      end else begin
        i_ready = 1'b1;
      end
      drive(nxt < 4, nxt + 1, nxt + 1, 1'b0, 1'b0);
      #1;
      if (!i_ready) begin
        chk($sformatf("bp_stall%0d_ready", hold), o_ready, 0);
        chk($sformatf("bp_stall%0d_S", hold), o_S, 2);
      end
      if (i_valid && o_ready) nxt++;
      if (o_valid && i_ready) begin
        if (got < 4) chk($sformatf("bp_out%0d", got), o_S, bp_exp[got]);
        else chk("bp_extra", got, 3);
        got++;
      end
      @(posedge i_clk);
      #1;
    end
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    chk("bp_accepted", nxt, 4);
    chk("bp_delivered", got, 4);

    // Reset with two operations in flight
    i_ready = 1'b0;
    drive(1'b1, 32'd10, 32'd10, 1'b0, 1'b0);
    @(posedge i_clk);
    #1;
    drive(1'b1, 32'd20, 32'd20, 1'b0, 1'b0);
    @(posedge i_clk);
    #1;
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    chk("mr_inflight", o_valid, 1);
    i_rst = 1'b1;
    @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    chk("mr_valid", o_valid, 0);
    i_ready = 1'b1;
    stale = 0;
    for (int c = 0; c < 6; c++) begin
      if (o_valid) stale++;
      @(posedge i_clk);
      #1;
    end
    chk("mr_stale", stale, 0);
    drive(1'b1, 32'd100, 32'd23, 1'b0, 1'b0);
    @(posedge i_clk);
    #1;
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    lat = 1;
    while (!o_valid && lat < 20) begin
      @(posedge i_clk);
      #1;
      lat++;
    end
    chk("mr_lat", lat, NS);
    chk("mr_S", o_S, 123);
    @(posedge i_clk);
    #1;

    // Random operands with random downstream readiness
    sent = 0;
    rcv  = 0;
    for (int cyc = 0; cyc < 3000 && rcv < 300; cyc++) begin
      i_ready = ($urandom_range(0, 3) != 0);
      ra = $urandom;
      rb = $urandom;
      rc = 1'($urandom_range(0, 1));
      rs = 1'($urandom_range(0, 1));
      drive(sent < 300 && $urandom_range(0, 3) != 0, ra, rb, rc, rs);
      #1;
      if (i_valid && o_ready) begin
        q.push_back(mdl(ra, rb, rc, rs));
        sent++;
      end
      if (o_valid && i_ready) begin
        if (q.size() > 0) begin
          e = q.pop_front();
          chk($sformatf("rnd%0d", rcv), {o_Ovf, o_Cout, o_S}, e);
        end else begin
          chk("rnd_extra", rcv, sent);
        end
        rcv++;
      end
      @(posedge i_clk);
      #1;
    end
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    chk("rnd_count", rcv, 300);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
